// File: rtl/trivium_stream_pkg.sv
// Shared constants, FSM encoding and state-load helper for the Trivium keystream engine.
package trivium_stream_pkg;
  localparam int TRIV_STATE_W     = 288;
  localparam int TRIV_INIT_ROUNDS = 1152;
  localparam int KEY_W            = 80;
  localparam int IV_W             = 80;

  // Trivium tap positions, 1-based as in the cipher definition
  localparam int T1A = 66;
  localparam int T1B = 93;
  localparam int T1C = 91;
  localparam int T1D = 92;
  localparam int T1E = 171;
  localparam int T2A = 162;
  localparam int T2B = 177;
  localparam int T2C = 175;
  localparam int T2D = 176;
  localparam int T2E = 264;
  localparam int T3A = 243;
  localparam int T3B = 288;
  localparam int T3C = 286;
  localparam int T3D = 287;
  localparam int T3E = 69;

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} triv_state_e;

  // Initial register image: key in s1..s80, iv in s94..s173, s286..s288 set.
  function automatic logic [TRIV_STATE_W:1] triv_load(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
    logic [TRIV_STATE_W:1] s;
    s          = '0;
    s[80:1]    = key;
    s[173:94]  = iv;
    s[288:286] = 3'b111;
    return s;
  endfunction
endpackage

// File: rtl/trivium_stream_if.sv
// Keystream output bus. Handshake: a word transfers on a rising clk edge where
// ks_valid & ks_ready; the producer holds data/last/bits stable while ks_valid & !ks_ready.
interface trivium_stream_if #(parameter int W = 8);
  logic         ks_valid;
  logic         ks_ready;
  logic [W-1:0] ks_data;
  logic         ks_last;
  logic [6:0]   ks_bits;

  modport master (output ks_valid, ks_data, ks_last, ks_bits, input ks_ready);
  modport slave  (input ks_valid, ks_data, ks_last, ks_bits, output ks_ready);
endinterface

// File: rtl/trivium_stream_round.sv
// W unrolled Trivium steps, purely combinational; z[k] is the output bit of step k.
module trivium_round
  import trivium_stream_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [TRIV_STATE_W:1] s,
  output logic [TRIV_STATE_W:1] s_next,
  output logic [W-1:0]          z
);
  always_comb begin
    logic [TRIV_STATE_W:1] st;
    logic t1, t2, t3;
    st = s;
    z  = '0;
    t1 = 1'b0;
    t2 = 1'b0;
    t3 = 1'b0;
    for (int k = 0; k < W; k++) begin
      t1   = st[T1A] ^ st[T1B];
      t2   = st[T2A] ^ st[T2B];
      t3   = st[T3A] ^ st[T3B];
      z[k] = t1 ^ t2 ^ t3;
      t1   = t1 ^ (st[T1C] & st[T1D]) ^ st[T1E];
      t2   = t2 ^ (st[T2C] & st[T2D]) ^ st[T2E];
      t3   = t3 ^ (st[T3C] & st[T3D]) ^ st[T3E];
      // Three shift registers, each taking its new bit in at the low end
      st   = {st[287:178], t2, st[176:94], t1, st[92:1], t3};
    end
    s_next = st;
  end
endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream engine: key/IV load, 1152-round warm-up, then len bits as W-bit words.
module trivium_stream
  import trivium_stream_pkg::*;
#(
  parameter int W     = 8,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [IV_W-1:0]    iv,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output triv_state_e        dbg_state,
  trivium_stream_if.master   ks
);
  localparam int INIT_CYC = TRIV_INIT_ROUNDS / W;
  localparam int CNT_W    = $clog2(INIT_CYC + 1);
  localparam logic [LEN_W-1:0] W_L = LEN_W'(W);

  triv_state_e           state, state_nxt;
  logic [TRIV_STATE_W:1] s, s_step;
  logic [W-1:0]          z, mask;
  logic [LEN_W-1:0]      rem;
  logic [CNT_W-1:0]      rcnt;
  logic                  run, hs, last_word;

  trivium_round #(.W(W)) u_round (.s(s), .s_next(s_step), .z(z));

  assign run       = (state == RUN);
  assign hs        = run & ks.ks_ready;
  assign last_word = (rem <= W_L);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len != '0) ? INIT : DONE;
      INIT: if (rcnt == CNT_W'(INIT_CYC - 1)) state_nxt = RUN;
      RUN:  if (hs && last_word) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s    <= '0;
      rem  <= '0;
      rcnt <= '0;
    end else begin
      case (state)
        IDLE: if (start && len != '0) begin
          s    <= triv_load(key, iv);
          rem  <= len;
          rcnt <= '0;
        end
        INIT: begin
          s    <= s_step;
          rcnt <= rcnt + CNT_W'(1);
        end
        // Only a handshake consumes keystream, so a stall holds the word
        RUN: if (hs) begin
          s   <= s_step;
          rem <= (rem > W_L) ? rem - W_L : '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < W; k++) mask[k] = (LEN_W'(k) < rem);
    busy        = (state == INIT) || run;
    done        = (state == DONE);
    ks.ks_valid = run;
    ks.ks_data  = run ? (z & mask) : '0;
    ks.ks_last  = run & last_word;
    ks.ks_bits  = !run ? 7'd0 : (last_word ? 7'(rem) : 7'(W));
  end
endmodule

// File: tb/tb_trivium_stream.sv
// Bench for trivium_stream: W=8 main instance plus W=1 and W=64 siblings, all checked
// against a bit-serial reference model through per-instance expected-word queues.
module tb_trivium_stream;
  import trivium_stream_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [6:0]  bits;
  } exp_t;

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    int          len;
    int          rmode;
    bit          noise;
    int          exp_words;
    int          exp_lbits;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start8 = 1'b0, starto = 1'b0;
  logic [79:0] key_i = '0, iv_i = '0;
  logic [15:0] len_i = '0;
  logic        busy8, done8, busy1, done1, busy64, done64;
  triv_state_e st8, st1, st64;

  trivium_stream_if #(.W(8))  a8 ();
  trivium_stream_if #(.W(1))  a1 ();
  trivium_stream_if #(.W(64)) a64 ();

  trivium_stream #(.W(8), .LEN_W(16)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .key(key_i), .iv(iv_i), .len(len_i),
    .busy(busy8), .done(done8), .dbg_state(st8), .ks(a8));
  trivium_stream #(.W(1), .LEN_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .start(starto), .key(key_i), .iv(iv_i), .len(len_i),
    .busy(busy1), .done(done1), .dbg_state(st1), .ks(a1));
  trivium_stream #(.W(64), .LEN_W(16)) u64 (
    .clk(clk), .reset_n(reset_n), .start(starto), .key(key_i), .iv(iv_i), .len(len_i),
    .busy(busy64), .done(done64), .dbg_state(st64), .ks(a64));

  always #5 clk = ~clk;

  int   tests = 0, fails = 0;
  exp_t exp8_q[$], exp1_q[$], exp64_q[$];
  bit   mbits[0:4095];
  int   hs8 = 0, hs1 = 0, hs64 = 0, dn8 = 0, dn1 = 0, dn64 = 0;
  int   in8 = 0, in1 = 0, in64 = 0;
  int   lb8 = 0;
  bit   pend8 = 0, pend1 = 0, pend64 = 0, stall8 = 0;
  logic [7:0] sd8;
  logic       sl8;
  logic [6:0] sb8;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Bit-serial reference: fills mbits with n keystream bits after warm-up.
  task automatic gen_model(input logic [79:0] k, input logic [79:0] v, input int n);
    bit s[1:288];
    bit t1, t2, t3, zb;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      s[i + 1]  = k[i];
      s[i + 94] = v[i];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < 1152 + n; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      zb = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i - 1];
      s[1] = t3; s[94] = t1; s[178] = t2;
      if (r >= 1152) mbits[r - 1152] = zb;
    end
  endtask

  task automatic push_exp(input int w, input int n);
    exp_t e;
    int   nw;
    nw = (n + w - 1) / w;
    for (int j = 0; j < nw; j++) begin
      e.data = '0;
      for (int k = 0; k < w; k++) if (j * w + k < n) e.data[k] = mbits[j * w + k];
      e.last = (j == nw - 1);
      e.bits = 7'((j == nw - 1) ? n - j * w : w);
      if (w == 1)      exp1_q.push_back(e);
      else if (w == 8) exp8_q.push_back(e);
      else             exp64_q.push_back(e);
    end
  endtask

  task automatic check_word(input int w, input logic [63:0] d, input logic l, input logic [6:0] b);
    exp_t e;
    int   sz;
    sz = (w == 1) ? exp1_q.size() : (w == 8) ? exp8_q.size() : exp64_q.size();
    tests++;
    if (sz == 0) begin
      fails++;
      $display("FAIL word_w%0d: unexpected word %0h last=%0b bits=%0d", w, d, l, b);
      return;
    end
    if (w == 1)      e = exp1_q.pop_front();
    else if (w == 8) e = exp8_q.pop_front();
    else             e = exp64_q.pop_front();
    if ({d, l, b} !== {e.data, e.last, e.bits}) begin
      fails++;
      $display("FAIL word_w%0d: got %0h/%0b/%0d expected %0h/%0b/%0d",
               w, d, l, b, e.data, e.last, e.bits);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend8 = 0; pend1 = 0; pend64 = 0; stall8 = 0;
      end else begin
        if (pend8) begin
          chk("done_after_last_w8", 64'(done8), 64'd1);
          chk("busy_low_in_done_w8", 64'(busy8), 64'd0);
          pend8 = 0;
        end
        if (pend1)  begin chk("done_after_last_w1", 64'(done1), 64'd1);   pend1 = 0;  end
        if (pend64) begin chk("done_after_last_w64", 64'(done64), 64'd1); pend64 = 0; end
        if (done8)  dn8++;
        if (done1)  dn1++;
        if (done64) dn64++;
        if (busy8 && !a8.ks_valid)   in8++;
        if (busy1 && !a1.ks_valid)   in1++;
        if (busy64 && !a64.ks_valid) in64++;
        if (stall8 && a8.ks_valid)
          chk("stall_hold_w8", {55'd0, a8.ks_data, a8.ks_last}, {55'd0, sd8, sl8});
        if (stall8 && a8.ks_valid) chk("stall_bits_w8", 64'(a8.ks_bits), 64'(sb8));
        stall8 = a8.ks_valid && !a8.ks_ready;
        sd8 = a8.ks_data; sl8 = a8.ks_last; sb8 = a8.ks_bits;
        if (a8.ks_valid && a8.ks_ready) begin
          check_word(8, 64'(a8.ks_data), a8.ks_last, a8.ks_bits);
          hs8++;
          if (a8.ks_last) begin pend8 = 1; lb8 = int'(a8.ks_bits); end
        end
        if (a1.ks_valid && a1.ks_ready) begin
          check_word(1, 64'(a1.ks_data), a1.ks_last, a1.ks_bits);
          hs1++;
          if (a1.ks_last) pend1 = 1;
        end
        if (a64.ks_valid && a64.ks_ready) begin
          check_word(64, a64.ks_data, a64.ks_last, a64.ks_bits);
          hs64++;
          if (a64.ks_last) pend64 = 1;
        end
      end
    end
  endtask

  task automatic run_txn(input vec_t v);
    int hb, d8b, d1b, d64b, i8b, i1b, i64b, cyc;
    gen_model(v.key, v.iv, v.len);
    push_exp(8, v.len); push_exp(1, v.len); push_exp(64, v.len);
    hb = hs8; d8b = dn8; d1b = dn1; d64b = dn64; i8b = in8; i1b = in1; i64b = in64;
    @(posedge clk); #1;
    start8 = 1'b1; starto = 1'b1;
    key_i = v.key; iv_i = v.iv; len_i = 16'(v.len);
    @(posedge clk); #1;
    start8 = 1'b0; starto = 1'b0;
    key_i = {$urandom(), $urandom(), 16'($urandom())}; iv_i = ~key_i;
    len_i = 16'($urandom_range(1, 500));
    cyc = 0;
    while (!(dn8 > d8b && dn1 > d1b && dn64 > d64b) && cyc < 12000) begin
      @(posedge clk); #1;
      cyc++;
      case (v.rmode)
        1:       begin a8.ks_ready = 1'($urandom_range(0, 1)); a1.ks_ready = 1'($urandom_range(0, 1)); end
        2:       a8.ks_ready = !(cyc >= 146 && cyc < 151);
        default: a8.ks_ready = 1'b1;
      endcase
      a64.ks_ready = a1.ks_ready;
      start8 = v.noise && (cyc == 50);
    end
    start8 = 1'b0;
    a8.ks_ready = 1'b1; a1.ks_ready = 1'b1; a64.ks_ready = 1'b1;
    if (cyc >= 12000) begin
      tests++; fails++;
      $display("FAIL txn_timeout: len=%0d not done within 12000 cycles", v.len);
    end
    chk("words_w8", 64'(hs8 - hb), 64'(v.exp_words));
    chk("last_bits_w8", 64'(lb8), 64'(v.exp_lbits));
    chk("init_cycles_w8", 64'(in8 - i8b), 64'd144);
    chk("init_cycles_w1", 64'(in1 - i1b), 64'd1152);
    chk("init_cycles_w64", 64'(in64 - i64b), 64'd18);
    chk("done_pulses_w8", 64'(dn8 - d8b), 64'd1);
    chk("queues_drained", 64'(exp8_q.size() + exp1_q.size() + exp64_q.size()), 64'd0);
  endtask

  function automatic logic [79:0] rnd80();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  initial begin
    int l, hb, d8b, cyc;
    a8.ks_ready = 1'b1; a1.ks_ready = 1'b1; a64.ks_ready = 1'b1;
    vecs[0] = '{80'hFF000102030405060708, 80'h0, 100, 0, 0, 13, 4};
    vecs[1] = '{rnd80(), rnd80(), 1,   0, 0, 1,  1};
    vecs[2] = '{rnd80(), rnd80(), 8,   1, 0, 1,  8};
    vecs[3] = '{rnd80(), rnd80(), 16,  0, 1, 2,  8};
    vecs[4] = '{rnd80(), rnd80(), 7,   1, 0, 1,  7};
    vecs[5] = '{rnd80(), rnd80(), 300, 1, 1, 38, 4};
    vecs[6] = '{rnd80(), rnd80(), 64,  2, 0, 8,  8};
    vecs[7] = '{{80{1'b1}}, {80{1'b1}}, 129, 1, 0, 17, 1};
    l = $urandom_range(1, 300);
    vecs[8] = '{rnd80(), rnd80(), l, 1, 0, (l + 7) / 8, l - ((l + 7) / 8 - 1) * 8};
    vecs[9] = '{rnd80(), rnd80(), 4096, 0, 0, 512, 8};

    fork monitor(); join_none

    #13;
    chk("reset_valid", 64'(a8.ks_valid), 64'd0);
    chk("reset_data", 64'(a8.ks_data), 64'd0);
    chk("reset_last_bits", {55'd0, a8.ks_last, a8.ks_bits}, 64'd0);
    chk("reset_busy_done", {62'd0, busy8, done8}, 64'd0);
    chk("reset_state", 64'(st8), 64'(IDLE));
    @(posedge clk); #1 reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // len == 0: no stream, done on the next cycle, busy never rises
    d8b = dn8;
    @(posedge clk); #1; start8 = 1'b1; len_i = '0;
    @(posedge clk); #1; start8 = 1'b0;
    chk("len0_done", 64'(done8), 64'd1);
    chk("len0_busy_valid", {62'd0, busy8, a8.ks_valid}, 64'd0);
    @(posedge clk); #1;
    chk("len0_done_single", 64'(done8), 64'd0);
    chk("len0_busy_valid_after", {62'd0, busy8, a8.ks_valid}, 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("len0_pulse_count", 64'(dn8 - d8b), 64'd1);

    // Reset while word 3 is presented, then a fresh stream from the same key
    gen_model(vecs[0].key, vecs[0].iv, 100);
    push_exp(8, 100);
    hb = hs8; d8b = dn8;
    @(posedge clk); #1;
    start8 = 1'b1; key_i = vecs[0].key; iv_i = vecs[0].iv; len_i = 16'd100;
    @(posedge clk); #1; start8 = 1'b0;
    cyc = 0;
    while (hs8 - hb < 2 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    chk("word3_reached", 64'(hs8 - hb), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_reset_valid_data", {55'd0, a8.ks_valid, a8.ks_data}, 64'd0);
    chk("midrun_reset_last_bits", {55'd0, a8.ks_last, a8.ks_bits}, 64'd0);
    chk("midrun_reset_busy_done", {62'd0, busy8, done8}, 64'd0);
    exp8_q.delete(); exp1_q.delete(); exp64_q.delete();
    repeat (3) @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("no_done_after_reset", 64'(dn8 - d8b), 64'd0);
    run_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
